// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and framing constants for the UART transmit path.
// Reused by the baud generator and any future RX path.
package fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned NUM_DATA_BITS = 8;
  localparam int unsigned FRAME_BITS    = NUM_DATA_BITS + 2;

  // Counter width for a divider; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: tick is high on the last cycle of every BAUD_DIV-cycle period.
// Zero latency from counter state to tick; clear holds the period at its first cycle.
module baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned   CW   = cnt_width(BAUD_DIV);
  localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an 8N1 UART line, LSB first; pop and latch share one IDLE cycle.
// Frame is 10*BAUD_DIV cycles plus one IDLE cycle between frames; FIFO_empty is only looked at in IDLE.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 104,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] I_DATA,
  input  logic                  FIFO_empty,
  input  logic                  TX_enable,
  output logic                  FIFO_pop,
  output logic                  TX,
  output logic                  TX_busy,
  output logic                  TX_done
);

  localparam logic [2:0] LAST_BIT = 3'(NUM_DATA_BITS - 1);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [2:0]            bit_idx_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  start_frame;
  logic                  baud_clear;
  logic                  baud_tick;

  // rst is gated here so a reset cycle can never pop a byte that is then dropped.
  assign start_frame = (state_q == IDLE) && TX_enable && !FIFO_empty && !rst;
  assign baud_clear  = (state_q == IDLE);

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (baud_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (start_frame) begin
            shift_q <= I_DATA;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          // The line register is loaded with the next bit at the boundary, so TX never lags the state.
          if (baud_tick) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign FIFO_pop = start_frame;
  assign TX       = tx_q;
  assign TX_busy  = busy_q;
  assign TX_done  = (state_q == STOP) && baud_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scenario bench for fifo_uart_tx with a timeline reference model of the 8N1 frame.
module tb_fifo_uart_tx;

  localparam int BD    = 4;
  localparam int FRAME = 10 * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] I_DATA = 8'h00;
  logic       FIFO_empty = 1'b1;
  logic       TX_enable = 1'b0;
  logic       FIFO_pop;
  logic       TX;
  logic       TX_busy;
  logic       TX_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .BAUD_DIV   (BD),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .I_DATA     (I_DATA),
    .FIFO_empty (FIFO_empty),
    .TX_enable  (TX_enable),
    .FIFO_pop   (FIFO_pop),
    .TX         (TX),
    .TX_busy    (TX_busy),
    .TX_done    (TX_done)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] fifo_q[$];
  logic       pop_pending = 1'b0;
  int         pop_log[$];
  int         done_log[$];

  // Reference timeline: a frame popped at cycle P occupies cycles P+1 .. P+FRAME.
  logic       m_active = 1'b0;
  int         m_start = 0;
  logic [7:0] m_byte = 8'h00;
  int         m_k;
  logic       m_in_frame;
  logic       exp_tx = 1'b1, exp_pop = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  always @(posedge clk) cyc++;

  // External FIFO: pops on the strobe seen last cycle, then presents the new head.
  always @(posedge clk) begin
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    #2;
    FIFO_empty = (fifo_q.size() == 0);
    I_DATA     = FIFO_empty ? 8'h00 : fifo_q[0];
  end

  always @(negedge clk) begin
    m_k        = cyc - m_start;
    m_in_frame = m_active && (m_k >= 1) && (m_k <= FRAME);
    exp_busy   = m_in_frame;
    exp_tx     = m_in_frame ? frame_bit(m_byte, (m_k - 1) / BD) : 1'b1;
    exp_done   = m_in_frame && (m_k == FRAME);
    exp_pop    = !m_in_frame && TX_enable && !FIFO_empty && !rst;
    pop_pending = (FIFO_pop === 1'b1);
    if (FIFO_pop === 1'b1) pop_log.push_back(cyc);
    if (TX_done === 1'b1) done_log.push_back(cyc);
    if (rst) begin
      m_active = 1'b0;
    end else if (exp_pop) begin
      m_active = 1'b1;
      m_start  = cyc;
      m_byte   = I_DATA;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      rst = (i < 3);
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL reset cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
    end
  endtask

  task automatic test_single();
    logic [9:0] got_bits;
    got_bits = '0;
    pop_log.delete(); done_log.delete();
    for (int i = 0; i < 46; i++) begin
      @(posedge clk); #2;
      if (i == 0) begin fifo_q.push_back(8'hA5); TX_enable = 1'b1; end
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL single cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
      if (pop_log.size() == 1) begin
        int k;
        k = cyc - pop_log[0];
        if (k >= 1 && k <= FRAME && ((k - 1) % BD) == 1) got_bits[(k-1)/BD] = TX;
      end
    end
    vectors++;
    if (pop_log.size() != 1) begin
      miscompares++;
      $display("FAIL single_pop_count got=%0d want=1", pop_log.size());
    end
    vectors++;
    if (got_bits !== 10'b1101001010) begin
      miscompares++;
      $display("FAIL single_line_bits got=%b want=%b", got_bits, 10'b1101001010);
    end
    vectors++;
    if (done_log.size() != 1 || pop_log.size() != 1 || done_log[0] - pop_log[0] != FRAME) begin
      miscompares++;
      $display("FAIL single_done_offset got=%0d pulses=%0d want offset=%0d", 
               (done_log.size() > 0 && pop_log.size() > 0) ? done_log[0] - pop_log[0] : -1,
               done_log.size(), FRAME);
    end
  endtask

  task automatic test_back_to_back();
    int busy_low;
    busy_low = 0;
    pop_log.delete(); done_log.delete();
    for (int i = 0; i < 90; i++) begin
      @(posedge clk); #2;
      if (i == 0) begin fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); TX_enable = 1'b1; end
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL b2b cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
      if (pop_log.size() >= 1 && cyc > pop_log[0] && cyc <= pop_log[0] + FRAME + 1 && TX_busy !== 1'b1)
        busy_low++;
    end
    vectors++;
    if (pop_log.size() != 2 || pop_log[1] - pop_log[0] != FRAME + 1) begin
      miscompares++;
      $display("FAIL b2b_pop_spacing pops=%0d gap=%0d want pops=2 gap=%0d", pop_log.size(),
               (pop_log.size() >= 2) ? pop_log[1] - pop_log[0] : -1, FRAME + 1);
    end
    vectors++;
    if (busy_low != 1) begin
      miscompares++;
      $display("FAIL b2b_busy_gap got=%0d want=1", busy_low);
    end
  endtask

  task automatic test_enable_gating();
    pop_log.delete(); done_log.delete();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (i == 0)  begin fifo_q.push_back(8'h3C); TX_enable = 1'b0; end
      if (i == 10) TX_enable = 1'b1;
      if (i == 20) begin TX_enable = 1'b0; fifo_q.push_back(8'h99); end
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL enable cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
    end
    vectors++;
    if (pop_log.size() != 1 || done_log.size() != 1) begin
      miscompares++;
      $display("FAIL enable_pops got pops=%0d dones=%0d want 1 and 1", pop_log.size(), done_log.size());
    end
    @(posedge clk); #2;
    fifo_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    pop_log.delete(); done_log.delete();
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #2;
      if (i == 0) begin fifo_q.push_back(8'h55); fifo_q.push_back(8'hAA); TX_enable = 1'b1; end
      rst = (pop_log.size() >= 1) && (cyc == pop_log[0] + 2 + 4 * BD + 2);
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL rst_mid cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
    end
    vectors++;
    if (pop_log.size() != 2 || pop_log[1] - pop_log[0] != 4 * BD + 5) begin
      miscompares++;
      $display("FAIL rst_mid_repop pops=%0d gap=%0d want pops=2 gap=%0d", pop_log.size(),
               (pop_log.size() >= 2) ? pop_log[1] - pop_log[0] : -1, 4 * BD + 5);
    end
  endtask

  task automatic test_empty_boundary();
    pop_log.delete(); done_log.delete();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (i == 0) begin fifo_q.push_back(8'($urandom_range(0, 255))); TX_enable = 1'b1; end
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL empty cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
    end
    vectors++;
    if (pop_log.size() != 1 || done_log.size() != 1) begin
      miscompares++;
      $display("FAIL empty_single_frame got pops=%0d dones=%0d want 1 and 1", pop_log.size(), done_log.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 15) == 0 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom_range(0, 255)));
      TX_enable = ($urandom_range(0, 7) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      @(negedge clk); #1;
      vectors++;
      if ({TX, FIFO_pop, TX_busy, TX_done} !== {exp_tx, exp_pop, exp_busy, exp_done}) begin
        miscompares++;
        $display("FAIL random cyc=%0d tx/pop/busy/done got=%b%b%b%b want=%b%b%b%b", cyc,
                 TX, FIFO_pop, TX_busy, TX_done, exp_tx, exp_pop, exp_busy, exp_done);
      end
    end
    @(posedge clk); #2;
    rst = 1'b0;
    TX_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_frame();
    test_empty_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
